// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: registered LC-3 execute stage with valid/ready handshakes; iterative SLL/SRA via a SHIFT state when EXEC_SHIFT_EN is defined
module exec_stage_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_alu_control,
  input  logic             i_alu_muxa,
  input  logic [2:0]       i_alu_muxb,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [15:0]      i_ir,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_n,
  output logic             o_z,
  output logic             o_p,
  output logic             o_of,
  output logic             o_busy
);
  localparam int M = WIDTH - 1;
  if (WIDTH < 16 || (1 << SHAMT_W) > WIDTH) begin : g_bad_params
    $error("exec_stage_pipe: WIDTH must be >= 16 and 2**SHAMT_W <= WIDTH");
  end
  logic [WIDTH-1:0] w_a, w_b, w_imm, w_res, w_ld_val;
  logic             w_of, w_slot, w_acc, w_start, w_done, w_ld, w_ld_of, w_idle;
  logic [WIDTH-1:0] r_y;
  logic             r_n, r_z, r_p, r_of, r_out_valid;
  always_comb begin
    w_a = i_alu_muxa ? i_rs1_data : i_pc;
    w_imm = i_alu_muxb[1]
      ? (i_alu_muxb[0] ? {{(WIDTH-11){i_ir[10]}}, i_ir[10:0]} : {{(WIDTH-9){i_ir[8]}}, i_ir[8:0]})
      : (i_alu_muxb[0] ? {{(WIDTH-6){i_ir[5]}}, i_ir[5:0]} : {{(WIDTH-5){i_ir[4]}}, i_ir[4:0]});
    w_b = i_alu_muxb[2] ? w_imm : i_rs2_data;
    w_res = '0;
    case (i_alu_control)
      3'd0: w_res = w_a + w_b;
      3'd1: w_res = w_a & w_b;
      3'd2: w_res = ~w_a;
      3'd3: w_res = w_a;
      3'd4: w_res = w_b;
      3'd5: w_res = w_a - w_b;
`ifdef EXEC_SHIFT_EN
      default: w_res = w_a;
`else
      default: w_res = w_b;
`endif
    endcase
    w_of = (i_alu_control == 3'd0 && w_a[M] == w_b[M] && w_res[M] != w_a[M]) ||
           (i_alu_control == 3'd5 && w_a[M] != w_b[M] && w_res[M] != w_a[M]);
  end
  assign w_slot = !r_out_valid || i_out_ready;
  assign o_in_ready = w_idle && !i_flush && w_slot;
  assign w_acc = i_in_valid && o_in_ready;
`ifdef EXEC_SHIFT_EN
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t             r_state;
  logic [WIDTH-1:0]   r_w, w_sh, w_fin;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_sra;
  assign w_idle  = r_state == IDLE;
  assign w_start = w_acc && i_alu_control[2:1] == 2'b11 && w_b[SHAMT_W-1:0] != '0;
  assign w_sh    = r_sra ? {r_w[M], r_w[M:1]} : {r_w[M-1:0], 1'b0};
  assign w_fin   = r_cnt == '0 ? r_w : w_sh;
  // The final shift and the result load share one edge, giving k+1 cycles of latency
  assign w_done  = r_state == SHIFT && r_cnt <= SHAMT_W'(1) && w_slot;
  assign o_busy  = r_state == SHIFT;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_w <= '0;
      r_cnt <= '0;
      r_sra <= 1'b0;
    end else if (i_flush) begin
      r_state <= IDLE;
    end else if (w_start) begin
      r_state <= SHIFT;
      r_w <= w_a;
      r_cnt <= w_b[SHAMT_W-1:0];
      r_sra <= i_alu_control[0];
    end else if (r_state == SHIFT) begin
      if (w_done) r_state <= IDLE;
      if (r_cnt != '0) begin
        r_w <= w_sh;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
  assign w_ld_val = w_done ? w_fin : w_res;
  assign w_ld_of  = !w_done && w_of;
`else
  assign w_idle   = 1'b1;
  assign w_start  = 1'b0;
  assign w_done   = 1'b0;
  assign o_busy   = 1'b0;
  assign w_ld_val = w_res;
  assign w_ld_of  = w_of;
`endif
  assign w_ld = (w_acc && !w_start) || w_done;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y <= '0;
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_p <= 1'b0;
      r_of <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else begin
      if (w_ld) begin
        r_y <= w_ld_val;
        r_n <= w_ld_val[M];
        r_z <= w_ld_val == '0;
        r_p <= !w_ld_val[M] && w_ld_val != '0;
        r_of <= w_ld_of;
      end
      r_out_valid <= w_ld || (r_out_valid && !i_out_ready);
    end
  end
  assign o_y = r_y;
  assign o_n = r_n;
  assign o_z = r_z;
  assign o_p = r_p;
  assign o_of = r_of;
  assign o_out_valid = r_out_valid;
endmodule

// File: tb/tb_exec_stage_pipe.sv
// tb_exec_stage_pipe: directed vectors against a spec-level model plus literal spot checks for exec_stage_pipe
module tb_exec_stage_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, i_flush = 1'b0, i_in_valid = 1'b0, i_out_ready = 1'b1;
  logic [2:0]  i_alu_control = '0, i_alu_muxb = '0;
  logic        i_alu_muxa = 1'b0;
  logic [15:0] i_pc = '0, i_ir = '0, i_rs1_data = '0, i_rs2_data = '0;
  logic        o_in_ready, o_out_valid, o_n, o_z, o_p, o_of, o_busy;
  logic [15:0] o_y;
  int n_checks = 0, n_pass = 0;
  typedef struct {logic [15:0] y; logic of;} exp_t;
  exp_t exp_q[$];

  exec_stage_pipe #(.WIDTH(16), .SHAMT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_alu_control(i_alu_control), .i_alu_muxa(i_alu_muxa), .i_alu_muxb(i_alu_muxb), .i_pc(i_pc),
    .i_ir(i_ir), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_y(o_y), .o_n(o_n), .o_z(o_z), .o_p(o_p), .o_of(o_of), .o_busy(o_busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, r;
    logic signed [15:0] a_s;
    exp_t e;
    sa = $signed(a);
    sb = $signed(b);
    a_s = a;
    e.of = 1'b0;
    e.y = '0;
    case (op)
      3'd0: begin r = sa + sb; e.y = r[15:0]; e.of = r > 32767 || r < -32768; end
      3'd1: e.y = a & b;
      3'd2: e.y = ~a;
      3'd3: e.y = a;
      3'd4: e.y = b;
      3'd5: begin r = sa - sb; e.y = r[15:0]; e.of = r > 32767 || r < -32768; end
`ifdef EXEC_SHIFT_EN
      default: e.y = op[0] ? 16'(a_s >>> b[3:0]) : a << b[3:0];
`else
      default: e.y = b;
`endif
    endcase
    return e;
  endfunction

  task automatic send(input logic [2:0] op, input logic ma, input logic [2:0] mb, input logic [15:0] pc,
                      input logic [15:0] ir, input logic [15:0] rs1, input logic [15:0] rs2, output int waits);
    int w, t;
    logic [15:0] a, b;
    @(negedge clk);
    i_alu_control = op; i_alu_muxa = ma; i_alu_muxb = mb; i_pc = pc; i_ir = ir;
    i_rs1_data = rs1; i_rs2_data = rs2; i_in_valid = 1'b1;
    waits = 0;
    #1;
    while (!o_in_ready && waits < 50) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!o_in_ready) chk("accept_timeout", o_in_ready, 1);
    else begin
      w = mb[1:0] == 2'd0 ? 5 : mb[1:0] == 2'd1 ? 6 : mb[1:0] == 2'd2 ? 9 : 11;
      t = int'(ir) << (32 - w);
      t = t >>> (32 - w);
      a = ma ? rs1 : pc;
      b = mb[2] ? t[15:0] : rs2;
      exp_q.push_back(ref_op(op, a, b));
    end
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic drain;
    i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Every cycle a result is presented it must match the oldest outstanding model entry
  always @(negedge clk) begin
    #3;
    if (rst_n && !i_flush && o_out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", o_out_valid, 0);
      else begin
        chk("model_y", o_y, exp_q[0].y);
        chk("model_of", o_of, exp_q[0].of);
        chk("model_nzp", {o_n, o_z, o_p}, {exp_q[0].y[15], exp_q[0].y == 0, !exp_q[0].y[15] && exp_q[0].y != 0});
        if (i_out_ready) void'(exp_q.pop_front());
      end
    end
  end

  logic [2:0]  t_op[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic [2:0]  t_mb[5] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b111};
  logic [15:0] t_rs1[5] = '{16'hF0F0, 16'h00FF, 16'h8001, 16'h0000, 16'h0100};
  logic [15:0] t_rs2[5] = '{16'h3C3C, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] t_ir[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0020, 16'h0400};

  initial begin
    int w;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_y", o_y, 0);
    chk("rst_nzp_of", {o_n, o_z, o_p, o_of}, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_in_ready", o_in_ready, 1);

    send(3'd0, 1'b1, 3'b100, 16'h0000, 16'h0001, 16'h7FFF, 16'h0000, w);
    chk("add_ovf_valid", o_out_valid, 1);
    chk("add_ovf_y", o_y, 16'h8000);
    chk("add_ovf_n_of", {o_n, o_of}, 2'b11);

    send(3'd0, 1'b0, 3'b110, 16'h3000, 16'h01FF, 16'h0000, 16'h0000, w);
    chk("off9_y", o_y, 16'h2FFF);
    chk("off9_p_of", {o_p, o_of}, 2'b10);
    drain();

    i_out_ready = 1'b0;
    send(3'd5, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h1234, 16'h1234, w);
    for (int i = 0; i < 3; i++) begin
      chk("stall_y_z", {o_y, o_z}, {16'h0000, 1'b1});
      chk("stall_hold", {o_out_valid, o_in_ready}, 2'b10);
      @(posedge clk); #1;
    end
    i_out_ready = 1'b1; #1;
    chk("stall_release_ready", o_in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      send(t_op[i], 1'b1, t_mb[i], 16'h0000, t_ir[i], t_rs1[i], t_rs2[i], w);
      chk("b2b_wait", w, 0);
    end
    send(3'd5, 1'b1, 3'b100, 16'h0000, 16'h0001, 16'h8000, 16'h0000, w);
    chk("sub_ovf_y", o_y, 16'h7FFF);
    chk("sub_ovf_p_of", {o_p, o_of}, 2'b11);
    drain();

    i_out_ready = 1'b0;
    send(3'd0, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0005, 16'h0003, w);
    @(negedge clk); i_flush = 1'b1; exp_q.delete(); #1;
    chk("flush_in_ready", o_in_ready, 0);
    @(negedge clk); i_flush = 1'b0; #1;
    chk("flush_kills_valid", o_out_valid, 0);
    chk("flush_keeps_y", o_y, 16'h0008);
    drain();

`ifdef EXEC_SHIFT_EN
    send(3'd7, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h8000, 16'h0004, w);
    for (int i = 0; i < 4; i++) begin
      chk("sra_busy", {o_busy, o_out_valid}, 2'b10);
      @(posedge clk); #1;
    end
    chk("sra_done", {o_busy, o_out_valid}, 2'b01);
    chk("sra_y_n", {o_y, o_n}, {16'hF800, 1'b1});
    send(3'd7, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, w);
    chk("sra0_y", {o_out_valid, o_y}, {1'b1, 16'h8000});
    send(3'd6, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0003, 16'h0003, w);
    repeat (3) @(posedge clk);
    #1;
    chk("sll3_y", o_y, 16'h0018);
    drain();

    send(3'd7, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h8000, 16'h0004, w);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0; exp_q.delete(); #1;
    chk("rst_mid_shift", {o_out_valid, o_busy, o_y}, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_mid_ready", o_in_ready, 1);

    send(3'd6, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0001, 16'h0008, w);
    @(posedge clk);
    @(negedge clk); i_flush = 1'b1; exp_q.delete();
    @(negedge clk); i_flush = 1'b0; #1;
    chk("flush_shift_idle", {o_busy, o_out_valid, o_in_ready}, 3'b001);
    repeat (10) @(posedge clk);
    #1;
    chk("flush_shift_quiet", {o_busy, o_out_valid}, 0);
    send(3'd0, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0002, 16'h0003, w);
    chk("post_flush_wait", w, 0);
    chk("post_flush_y", o_y, 16'h0005);
`else
    send(3'd6, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h1111, 16'hABCD, w);
    chk("sll_passb_y", {o_y, o_n, o_of}, {16'hABCD, 1'b1, 1'b0});
    send(3'd7, 1'b1, 3'b100, 16'h0000, 16'h0010, 16'h2222, 16'h0000, w);
    chk("sra_passb_y", o_y, 16'hFFF0);
    chk("noshift_busy", o_busy, 0);
`endif
    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
